// File: rtl/mqueue_host_out_slot.sv
// Outgoing host message-queue slot: CPU claims/fills/commits, host reads/discards.
// Optional MQUEUE_SLOT_STATS_EN adds saturating commit and claim-error counters.
module mqueue_host_out_slot #(
  parameter int g_ENTRIES_LOG2 = 2,
  parameter int g_WORDS_LOG2   = 7
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_i,
  input  logic                      in_claim_i,
  input  logic                      in_we_i,
  input  logic [g_WORDS_LOG2-1:0]   in_addr_i,
  input  logic [31:0]               in_data_i,
  input  logic                      in_commit_i,
  input  logic                      in_purge_i,
  input  logic [g_WORDS_LOG2-1:0]   out_addr_i,
  output logic [31:0]               out_data_o,
  input  logic                      out_discard_i,
  input  logic                      out_purge_i,
  output logic [g_ENTRIES_LOG2:0]   count_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      claimed_o,
  output logic                      claim_err_o,
  output logic                      irq_o
`ifdef MQUEUE_SLOT_STATS_EN
  ,
  output logic [15:0]               stat_commits_o,
  output logic [15:0]               stat_claim_errs_o
`endif
);

  localparam int E = g_ENTRIES_LOG2;
  localparam int W = g_WORDS_LOG2;
  localparam int DEPTH = 1 << (E + W);
  localparam logic [E:0] FULL_CNT = (E + 1)'(1 << E);

  typedef enum logic {
    ST_IDLE,
    ST_CLAIMED
  } state_t;

  state_t        state_q, state_d;
  logic [E-1:0]  wr_ptr_q, wr_ptr_d;
  logic [E-1:0]  rd_ptr_q, rd_ptr_d;
  logic [E:0]    count_q, count_d;
  logic          claim_err_q, claim_err_d;
  logic [31:0]   out_data_q, out_data_d;
  logic          purge, full, empty;
  logic          commit, discard, ram_we;

  logic [31:0]   mem [DEPTH];

  assign purge = in_purge_i | out_purge_i;
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    claim_err_d = 1'b0;
    commit      = 1'b0;
    discard     = 1'b0;
    ram_we      = 1'b0;
    if (purge) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_claim_i) begin
            if (full) claim_err_d = 1'b1;
            else      state_d = ST_CLAIMED;
          end
        end
        ST_CLAIMED: begin
          ram_we = in_we_i;
          if (in_claim_i) claim_err_d = 1'b1;
          if (in_commit_i) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      endcase
      discard = out_discard_i & ~empty;
      if (commit)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (discard) rd_ptr_d = rd_ptr_q + 1'b1;
      // Commit and discard together leave occupancy unchanged
      if (commit & ~discard)      count_d = count_q + 1'b1;
      else if (discard & ~commit) count_d = count_q - 1'b1;
    end
  end

  assign out_data_d = mem[{rd_ptr_q, out_addr_i}];

  always_ff @(posedge clk_sys_i) begin
    if (ram_we) mem[{wr_ptr_q, in_addr_i}] <= in_data_i;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      claim_err_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      claim_err_q <= claim_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign claimed_o   = (state_q == ST_CLAIMED);
  assign claim_err_o = claim_err_q;
  assign irq_o       = ~empty;

`ifdef MQUEUE_SLOT_STATS_EN
  logic [15:0] stat_commits_q, stat_commits_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_commits_d = stat_commits_q;
    stat_errs_d    = stat_errs_q;
    if (purge) begin
      stat_commits_d = '0;
      stat_errs_d    = '0;
    end else begin
      if (commit && stat_commits_q != 16'hFFFF)
        stat_commits_d = stat_commits_q + 16'd1;
      if (claim_err_d && stat_errs_q != 16'hFFFF)
        stat_errs_d = stat_errs_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      stat_commits_q <= '0;
      stat_errs_q    <= '0;
    end else begin
      stat_commits_q <= stat_commits_d;
      stat_errs_q    <= stat_errs_d;
    end
  end

  assign stat_commits_o    = stat_commits_q;
  assign stat_claim_errs_o = stat_errs_q;
`endif

endmodule
